// File: rtl/util_cp_remove_pkg.sv
// Shared types and constants for the cyclic-prefix removal stage.
// Covers the framing state encoding, the error codes and the FIFO entry layout.
package util_cp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SKIP = 2'b01,
        DATA = 2'b10,
        DROP = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_TRUNC = 2'b01
    } err_e;

    // Entry layout, MSB first: {error[1:0], sop, eop, real, imag}
    function automatic int entry_width(input int data_width);
        return 2 * data_width + 4;
    endfunction

endpackage

// File: rtl/util_cp_remove_if.sv
// Stream interface of the CP removal stage: the ADC-side input and the FFT-side output.
// The slave modport is the block's own view; the master modport is its environment.
interface util_cp_remove_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CP_WIDTH   = 10
);
    logic                  din_valid;
    logic                  din_sym_start;
    logic [CP_WIDTH-1:0]   din_cp_len;
    logic [DATA_WIDTH-1:0] din_real;
    logic [DATA_WIDTH-1:0] din_imag;
    logic                  dout_ready;
    logic                  dout_valid;
    logic                  dout_sop;
    logic                  dout_eop;
    logic [DATA_WIDTH-1:0] dout_real;
    logic [DATA_WIDTH-1:0] dout_imag;
    logic [1:0]            dout_error;
    logic                  err_sync;
    logic                  err_ovf;

    modport slave (
        input  din_valid, din_sym_start, din_cp_len, din_real, din_imag, dout_ready,
        output dout_valid, dout_sop, dout_eop, dout_real, dout_imag, dout_error,
               err_sync, err_ovf
    );

    modport master (
        output din_valid, din_sym_start, din_cp_len, din_real, din_imag, dout_ready,
        input  dout_valid, dout_sop, dout_eop, dout_real, dout_imag, dout_error,
               err_sync, err_ovf
    );
endinterface

// File: rtl/util_cp_remove_fifo.sv
// Synchronous first-word-fall-through FIFO with an exposed fill count.
// Holds no framing knowledge; the caller never pushes into a full FIFO.
module util_cp_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_fill
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic             w_pop;

    assign w_pop = i_pop & (r_fill != '0);

    // NOTE: the storage array is not reset; pointers and fill alone say which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_fill <= r_fill + (AW+1)'(1);
                2'b01:   r_fill <= r_fill - (AW+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;
endmodule

// File: rtl/util_cp_remove.sv
// Cyclic-prefix removal: drops CP samples and frames FFT_SIZE samples per symbol into a FIFO.
// A FIFO about to overflow gets a terminator entry, so every emitted frame still ends with eop.
module util_cp_remove
    import util_cp_pkg::*;
#(
    parameter int FFT_SIZE   = 1024,
    parameter int INDX_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int CP_WIDTH   = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input logic             clk,
    input logic             rst_n,
    util_cp_remove_if.slave bus
);
    localparam int                    EW        = entry_width(DATA_WIDTH);
    localparam logic [INDX_WIDTH-1:0] LAST_IDX  = INDX_WIDTH'(FFT_SIZE - 1);
    localparam logic [FIFO_AW:0]      SAFE_FILL = (FIFO_AW + 1)'(FIFO_DEPTH - 1);

    state_e                r_state;
    state_e                w_next_state;
    state_e                w_data_next;
    logic [CP_WIDTH-1:0]   r_cp_len;
    logic [CP_WIDTH-1:0]   r_cp_cnt;
    logic [INDX_WIDTH-1:0] r_idx;
    logic [INDX_WIDTH-1:0] w_cur_idx;
    logic                  r_err_sync;
    logic                  r_err_ovf;
    logic                  w_beat;
    logic                  w_start;
    logic                  w_can_start;
    logic                  w_zero_cp;
    logic                  w_data_beat;
    logic                  w_last;
    logic                  w_room;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [FIFO_AW:0]      w_fill;
    logic [EW-1:0]         w_wr_data;
    logic [EW-1:0]         w_rd_data;

    assign w_beat      = bus.din_valid;
    assign w_start     = bus.din_valid & bus.din_sym_start;
    assign w_can_start = (r_state == IDLE) || (r_state == SKIP);
    assign w_zero_cp   = (bus.din_cp_len == '0);
    // A zero-length CP makes the start beat itself data index 0.
    assign w_data_beat = w_beat & ((r_state == DATA) | (w_start & w_can_start & w_zero_cp));
    assign w_cur_idx   = (r_state == DATA) ? r_idx : '0;
    assign w_last      = (w_cur_idx == LAST_IDX);
    assign w_room      = (w_fill < SAFE_FILL);
    assign w_data_next = w_last ? IDLE : (w_room ? DATA : DROP);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: assign a default first so every path drives w_next_state and no latch appears.
    always_comb begin
        w_next_state = r_state;
        if (w_beat) begin
            case (r_state)
                IDLE, SKIP: begin
                    if (w_start) begin
                        if (w_zero_cp)                                w_next_state = w_data_next;
                        else if (bus.din_cp_len == CP_WIDTH'(1))      w_next_state = DATA;
                        else                                          w_next_state = SKIP;
                    end else if (r_state == SKIP &&
                                 (r_cp_cnt + CP_WIDTH'(1)) == r_cp_len) begin
                        w_next_state = DATA;
                    end
                end
                DATA:    w_next_state = w_data_next;
                DROP:    if (r_idx == LAST_IDX) w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses <= so every register sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cp_len   <= '0;
            r_cp_cnt   <= '0;
            r_idx      <= '0;
            r_err_sync <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else if (w_beat) begin
            if (w_start && w_can_start) begin
                r_cp_len <= bus.din_cp_len;
                r_cp_cnt <= CP_WIDTH'(1);
                r_idx    <= w_zero_cp ? INDX_WIDTH'(1) : '0;
            end else if (r_state == SKIP) begin
                r_cp_cnt <= r_cp_cnt + CP_WIDTH'(1);
            end else if (r_state == DATA || r_state == DROP) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + INDX_WIDTH'(1);
            end
            if (w_start && r_state != IDLE) r_err_sync <= 1'b1;
            if (w_data_beat && !w_room)     r_err_ovf  <= 1'b1;
        end
    end

    always_comb begin
        w_push    = w_data_beat;
        w_wr_data = {ERR_OK, (w_cur_idx == '0), w_last, bus.din_real, bus.din_imag};
        if (!w_room) begin
            w_wr_data = {ERR_TRUNC, (w_cur_idx == '0), 1'b1, {(2 * DATA_WIDTH){1'b0}}};
        end
        w_pop          = !w_empty & bus.dout_ready;
        bus.dout_valid = !w_empty;
        bus.dout_error = w_empty ? 2'b00 : w_rd_data[EW-1 -: 2];
        bus.dout_sop   = !w_empty & w_rd_data[EW-3];
        bus.dout_eop   = !w_empty & w_rd_data[EW-4];
        bus.dout_real  = w_rd_data[2*DATA_WIDTH-1 : DATA_WIDTH];
        bus.dout_imag  = w_rd_data[DATA_WIDTH-1 : 0];
        bus.err_sync   = r_err_sync;
        bus.err_ovf    = r_err_ovf;
    end

    util_cp_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_wr_data),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_empty (w_empty),
        .o_fill  (w_fill)
    );
endmodule

// File: tb/tb_util_cp_remove.sv
// Randomized bench for util_cp_remove: expected frames come from a positional model of the beat stream.
// Small configuration (16-point FFT, 8-entry FIFO) keeps every scenario short.
module tb_util_cp_remove;
    localparam int FFT   = 16;
    localparam int IW    = 4;
    localparam int DW    = 16;
    localparam int CW    = 10;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct packed {
        logic          start;
        logic [CW-1:0] cp;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } beat_t;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [1:0]    err;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    util_cp_remove_if #(.DATA_WIDTH(DW), .CP_WIDTH(CW)) bus ();

    util_cp_remove #(
        .FFT_SIZE   (FFT),
        .INDX_WIDTH (IW),
        .DATA_WIDTH (DW),
        .CP_WIDTH   (CW),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks      = 0;
    int    errors      = 0;
    int    cyc         = 0;
    int    first_valid = -1;
    int    mark_idx    = -1;
    int    mark_cyc    = -1;
    beat_t stim[$];
    out_t  exp_q[$];
    out_t  got[$];
    out_t  col_o;
    bit    exp_sync;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.dout_valid && bus.dout_ready) begin
            col_o = {bus.dout_sop, bus.dout_eop, bus.dout_error, bus.dout_real, bus.dout_imag};
            got.push_back(col_o);
        end
        if (rst_n && bus.dout_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (bus.dout_valid === 1'b0) begin
            checks++;
            if ({bus.dout_sop, bus.dout_eop, bus.dout_error} !== 4'b0) begin
                errors++;
                $display("FAIL idle_mask sop=%b eop=%b err=%b required 0", bus.dout_sop,
                         bus.dout_eop, bus.dout_error);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic add_symbol(input int cp, input int n_after, input int spur_at);
        beat_t b;
        b.start = 1'b1; b.cp = CW'(cp); b.re = DW'($urandom); b.im = DW'($urandom);
        stim.push_back(b);
        for (int k = 1; k < cp + FFT + n_after; k++) begin
            b.start = (k == spur_at);
            b.cp    = CW'($urandom_range(0, 7));
            b.re    = DW'($urandom);
            b.im    = DW'($urandom);
            stim.push_back(b);
        end
    endtask

    task automatic add_noise(input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.start = 1'b0; b.cp = CW'($urandom); b.re = DW'($urandom); b.im = DW'($urandom);
            stim.push_back(b);
        end
    endtask

    // Positional model: locate each start, follow CP restarts, take the next FFT beats.
    task automatic run_model(input bit stall);
        int   i, s, j, n, cp;
        bit   moved;
        out_t o;
        exp_q.delete();
        exp_sync = 1'b0;
        n = stim.size();
        i = 0;
        while (i < n) begin
            if (!stim[i].start) begin
                i++;
            end else begin
                s = i;
                moved = 1'b1;
                while (moved) begin
                    moved = 1'b0;
                    cp = int'(stim[s].cp);
                    for (int k = s + 1; k < s + cp && k < n; k++) begin
                        if (stim[k].start) begin
                            exp_sync = 1'b1; s = k; moved = 1'b1;
                            break;
                        end
                    end
                end
                j = s + int'(stim[s].cp);
                for (int d = 0; d < FFT && j + d < n; d++) begin
                    if (j + d != s && stim[j+d].start) exp_sync = 1'b1;
                    if (stall && d >= DEPTH - 1) begin
                        if (d == DEPTH - 1) begin
                            o = {(d == 0), 1'b1, 2'b01, {(2*DW){1'b0}}};
                            exp_q.push_back(o);
                        end
                    end else begin
                        o = {(d == 0), (d == FFT - 1), 2'b00, stim[j+d].re, stim[j+d].im};
                        exp_q.push_back(o);
                    end
                end
                i = j + FFT;
            end
        end
    endtask

    task automatic drive(input int gap_mode);
        int gaps;
        for (int k = 0; k < stim.size(); k++) begin
            bus.din_valid     = 1'b1;
            bus.din_sym_start = stim[k].start;
            bus.din_cp_len    = stim[k].cp;
            bus.din_real      = stim[k].re;
            bus.din_imag      = stim[k].im;
            @(posedge clk); #1;
            if (k == mark_idx) mark_cyc = cyc;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                bus.din_valid     = 1'b0;
                bus.din_sym_start = 1'($urandom_range(0, 1));
                bus.din_real      = DW'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.din_valid     = 1'b0;
        bus.din_sym_start = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        stim.delete();
        first_valid = -1;
        mark_idx    = -1;
        mark_cyc    = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.din_valid = 1'b1; bus.din_sym_start = 1'b1; bus.din_cp_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", bus.dout_valid); end
        if (bus.dout_sop !== 1'b0)   begin errors++; $display("FAIL reset_sop got %b required 0", bus.dout_sop); end
        if (bus.dout_eop !== 1'b0)   begin errors++; $display("FAIL reset_eop got %b required 0", bus.dout_eop); end
        if (bus.dout_error !== 2'b0) begin errors++; $display("FAIL reset_error got %b required 00", bus.dout_error); end
        if (bus.err_sync !== 1'b0)   begin errors++; $display("FAIL reset_err_sync got %b required 0", bus.err_sync); end
        if (bus.err_ovf !== 1'b0)    begin errors++; $display("FAIL reset_err_ovf got %b required 0", bus.err_ovf); end
        bus.din_valid = 1'b0; bus.din_sym_start = 1'b0;
        apply_reset();
    endtask

    task automatic test_nominal();
        beat_t b;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            b.start = (k == 0); b.cp = CW'(4); b.re = DW'(k); b.im = DW'($urandom);
            stim.push_back(b);
        end
        mark_idx = 4;
        run_model(1'b0);
        drive(0);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== exp_q.size()) begin errors++; $display("FAIL nominal_count got %0d required %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL nominal_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        checks++;
        if (first_valid !== mark_cyc) begin errors++; $display("FAIL nominal_latency first valid cycle %0d required %0d", first_valid, mark_cyc); end
        checks++;
        if ({bus.err_sync, bus.err_ovf} !== 2'b00) begin errors++; $display("FAIL nominal_flags got %b required 00", {bus.err_sync, bus.err_ovf}); end
    endtask

    task automatic test_zero_cp_back_to_back();
        apply_reset();
        add_symbol(0, 0, -1);
        add_symbol(0, 0, -1);
        run_model(1'b0);
        drive(1);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== 32) begin errors++; $display("FAIL b2b_count got %0d required 32", got.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        checks++;
        if ({bus.err_sync, bus.err_ovf} !== 2'b00) begin errors++; $display("FAIL b2b_flags got %b required 00", {bus.err_sync, bus.err_ovf}); end
    endtask

    task automatic test_start_in_skip();
        beat_t b;
        apply_reset();
        for (int k = 0; k < 3 + 2 + FFT + 2; k++) begin
            b.start = (k == 0) || (k == 3);
            b.cp    = (k == 0) ? CW'(6) : CW'(2);
            b.re    = DW'($urandom); b.im = DW'($urandom);
            stim.push_back(b);
        end
        run_model(1'b0);
        drive(0);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== FFT) begin errors++; $display("FAIL skip_count got %0d required %0d", got.size(), FFT); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL skip_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        checks++;
        if (bus.err_sync !== 1'b1) begin errors++; $display("FAIL skip_err_sync got %b required 1", bus.err_sync); end
    endtask

    task automatic test_start_in_data();
        int cp;
        apply_reset();
        cp = int'($urandom_range(1, 5));
        add_symbol(cp, 4, cp + 5);
        run_model(1'b0);
        drive(2);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== FFT) begin errors++; $display("FAIL data_count got %0d required %0d", got.size(), FFT); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL data_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        checks++;
        if (bus.err_sync !== 1'b1) begin errors++; $display("FAIL data_err_sync got %b required 1", bus.err_sync); end
    endtask

    task automatic test_overflow();
        apply_reset();
        bus.dout_ready = 1'b0;
        add_symbol(int'($urandom_range(0, 5)), 0, -1);
        run_model(1'b1);
        drive(0);
        repeat (5) @(negedge clk);
        checks += 2;
        if (got.size() !== 0)     begin errors++; $display("FAIL ovf_stalled_count got %0d required 0", got.size()); end
        if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b required 1", bus.err_ovf); end
        bus.dout_ready = 1'b1;
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== DEPTH) begin errors++; $display("FAIL ovf_count got %0d required %0d", got.size(), DEPTH); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        got.delete();
        stim.delete();
        add_symbol(int'($urandom_range(0, 5)), 0, -1);
        run_model(1'b0);
        drive(0);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== FFT) begin errors++; $display("FAIL ovf_next_count got %0d required %0d", got.size(), FFT); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_next_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        checks++;
        if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", bus.err_ovf); end
    endtask

    task automatic test_reset_mid_frame();
        int cp;
        apply_reset();
        cp = int'($urandom_range(1, 4));
        add_symbol(cp, 0, cp + 3);
        while (stim.size() > cp + 8) void'(stim.pop_back());
        drive(0);
        checks++;
        if (bus.err_sync !== 1'b1) begin errors++; $display("FAIL rstmid_pre_sync got %b required 1", bus.err_sync); end
        bus.din_valid = 1'b1; bus.din_sym_start = 1'b0; bus.din_real = DW'($urandom);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.din_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b required 0", bus.dout_valid); end
        if ({bus.err_sync, bus.err_ovf} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b required 00", {bus.err_sync, bus.err_ovf}); end
        got.delete();
        stim.delete();
        add_noise(7);
        add_symbol(int'($urandom_range(0, 6)), 0, -1);
        run_model(1'b0);
        drive(2);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== FFT) begin errors++; $display("FAIL rstmid_count got %0d required %0d", got.size(), FFT); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL rstmid_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
    endtask

    task automatic test_random_stream();
        int cp;
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            add_noise(int'($urandom_range(0, 3)));
            cp = int'($urandom_range(0, 7));
            add_symbol(cp, 0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, cp + FFT - 1)) : -1);
        end
        add_noise(24);
        run_model(1'b0);
        drive(2);
        wait_out(exp_q.size());
        checks++;
        if (got.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d required %0d", got.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin errors++; $display("FAIL rand_beat[%0d] got %h required %h", k, got[k], exp_q[k]); end
        end
        checks += 2;
        if (bus.err_sync !== exp_sync) begin errors++; $display("FAIL rand_err_sync got %b required %b", bus.err_sync, exp_sync); end
        if (bus.err_ovf !== 1'b0)      begin errors++; $display("FAIL rand_err_ovf got %b required 0", bus.err_ovf); end
    endtask

    initial begin
        bus.din_valid     = 1'b0;
        bus.din_sym_start = 1'b0;
        bus.din_cp_len    = '0;
        bus.din_real      = '0;
        bus.din_imag      = '0;
        bus.dout_ready    = 1'b1;
        test_reset();
        test_nominal();
        test_zero_cp_back_to_back();
        test_start_in_skip();
        test_start_in_data();
        test_overflow();
        test_reset_mid_frame();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
